sc_start_row_shifter: RTL
=========================

# sc_start_row_shifter

Sequential stage directly downstream of the start-pattern selector mux. It captures the selected 8-bit start pattern on a load strobe and shifts it one position per prescaled tick, in a direction fixed at load time. It reports busy while running and emits a one-cycle done pulse when the pattern is exhausted or the shift budget is spent. Its output row feeds the display/compare logic of the project.

## Interface

- DATAWIDTH, 8, width of the start pattern and output row; equals the selector output width
- TICK_PERIOD, 10, clock cycles per shift step; must be ≥ 2
- SHIFT_COUNT, 8, maximum shifts per run; must be ≥ 1

Ports:

- SC_STARTSHIFT_CLOCK_50  in  1  system clock; all state updates on its rising edge
- SC_STARTSHIFT_RESET_InHigh  in  1  reset, synchronous and active-high
- SC_STARTSHIFT_load_In  in  1  load strobe; sampled every edge
- SC_STARTSHIFT_dir_In  in  1  shift direction: 0 = left (toward MSB), 1 = right; sampled only with a load
- SC_STARTSHIFT_pause_In  in  1  freezes the tick counter while high
- SC_STARTSHIFT_data_InBUS  in  DATAWIDTH  start pattern from the selector mux
- SC_STARTSHIFT_data_OutBUS  out  DATAWIDTH  current row register
- SC_STARTSHIFT_busy_Out  out  1  high while in RUN
- SC_STARTSHIFT_done_Out  out  1  one-cycle pulse at the end of a run

## Operation

- State machine has three states: IDLE, RUN and DONE. Reset state is IDLE.
- Internal registers:
  - row register (DATAWIDTH)
  - latched direction bit
  - tick counter, width $clog2(TICK_PERIOD), range 0..TICK_PERIOD-1
  - shift counter, width $clog2(SHIFT_COUNT+1)
- IDLE: busy=0, done=0. The row holds its last value. On load_In=1:
  - row ← data_InBUS
  - direction ← dir_In
  - both counters ← 0
  - state → RUN
- RUN: busy=1.
  - With pause_In=1, all counters and the row hold.
  - Otherwise the tick counter increments. When it equals TICK_PERIOD-1, it wraps to 0 and one shift step occurs.
  - A shift step is a logical shift by 1 with zero fill (left: row<<1, right: row>>1). The shift counter increments by 1.
  - If the shift counter reaches SHIFT_COUNT, or the post-shift row equals 0, the state goes to DONE on that same edge.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE. The row keeps its final value (0 if exhausted).
- load_In=1 in RUN restarts the run with identical effect to a load in IDLE. The restart has priority over a coincident shift step. No done pulse is produced for the aborted run.
- load_In=1 in DONE: the done pulse is still emitted this cycle, and the load is accepted (state → RUN, not IDLE).
- pause_In in IDLE or DONE has no effect. A coincident load is not blocked by pause.
- A zero pattern is loaded normally. It finishes after the first shift step, because the post-shift row is 0.
- Direction changes on dir_In during RUN are ignored.

## Timing

- Reset values: data_OutBUS=0, busy_Out=0, done_Out=0, state IDLE, counters 0. Reset asserted mid-run aborts immediately, with no done pulse.
- All outputs are registered; there is no combinational input-to-output path.
- Load sampled at edge k:
  - data_OutBUS equals the loaded pattern and busy_Out=1 from edge k.
  - With no pause, the first shift is at edge k+TICK_PERIOD; shift n is at edge k+n·TICK_PERIOD.
- End of run at shift n (edge k+n·TICK_PERIOD):
  - busy_Out falls and done_Out rises at that edge.
  - done_Out falls at the next edge.
- Each paused cycle delays all subsequent shifts by exactly one cycle.
- Maximum run length is SHIFT_COUNT·TICK_PERIOD cycles, plus pause cycles.

## Test plan

- Reset, then no stimulus for 20 cycles -> data_OutBUS=0x00, busy_Out=0, done_Out=0 throughout.
- Load 0x01 with dir=0 at edge k -> rows 0x02, 0x04, …, 0x80 at edges k+10 … k+70. At k+80 the row is 0x00 and done_Out pulses for one cycle; busy_Out is high over k..k+79.
- Load 0x81 with dir=1 -> 0x40 at k+10, 0x20 at k+20, …, 0x01 at k+70, 0x00 with a done pulse at k+80. Toggling dir_In during the run has no effect.
- Load 0x00 -> busy for 10 cycles, row stays 0x00, done pulses at k+10.
- Load 0x0F with dir=0, then hold pause_In high for 5 cycles starting at k+3 -> first shift (0x1E) at k+15 instead of k+10.
- Load 0xF0 with dir=0, then re-load 0x03 with dir=1 at k+25 -> row 0x03 at k+25, no done pulse for the first run, row 0x01 at k+35, done at k+45. Separately, assert reset at k+5 of a run -> all outputs 0 at the next edge, no done pulse.

Source files
------------

// File: rtl/sc_start_row_shifter.sv
// ---------------------------------------------------------------------------
// sc_start_row_shifter
//
// Captures the start pattern chosen by the selector mux on a load strobe.
// Then, once every TICK_PERIOD unpaused clock cycles, it shifts the pattern
// by one position with zero fill. The shift direction is fixed when the
// pattern is loaded. A run ends when the row becomes all-zero or when
// SHIFT_COUNT shifts have been made. The end of a run is signalled by a
// one-cycle done pulse.
//
// Ports
//   SC_STARTSHIFT_CLOCK_50      in   system clock, rising-edge active
//   SC_STARTSHIFT_RESET_InHigh  in   synchronous active-high reset
//   SC_STARTSHIFT_load_In       in   load / restart strobe
//   SC_STARTSHIFT_dir_In        in   0 = shift toward MSB, 1 = toward LSB
//   SC_STARTSHIFT_pause_In      in   freezes the run while high
//   SC_STARTSHIFT_data_InBUS    in   start pattern (DATAWIDTH)
//   SC_STARTSHIFT_data_OutBUS   out  current row register (DATAWIDTH)
//   SC_STARTSHIFT_busy_Out      out  high while a run is in progress
//   SC_STARTSHIFT_done_Out      out  one-cycle end-of-run pulse
// ---------------------------------------------------------------------------
module sc_start_row_shifter #(
  parameter int DATAWIDTH   = 8,
  parameter int TICK_PERIOD = 10,
  parameter int SHIFT_COUNT = 8
) (
  input  logic                 SC_STARTSHIFT_CLOCK_50,
  input  logic                 SC_STARTSHIFT_RESET_InHigh,
  input  logic                 SC_STARTSHIFT_load_In,
  input  logic                 SC_STARTSHIFT_dir_In,
  input  logic                 SC_STARTSHIFT_pause_In,
  input  logic [DATAWIDTH-1:0] SC_STARTSHIFT_data_InBUS,
  output logic [DATAWIDTH-1:0] SC_STARTSHIFT_data_OutBUS,
  output logic                 SC_STARTSHIFT_busy_Out,
  output logic                 SC_STARTSHIFT_done_Out
);

  localparam int TW = $clog2(TICK_PERIOD);
  localparam int SW = $clog2(SHIFT_COUNT + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [SW-1:0] SHIFT_MAX = SW'(SHIFT_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [DATAWIDTH-1:0] row, row_n, row_shifted;
  logic                 dir, dir_n;
  logic [TW-1:0]        tick, tick_n;
  logic [SW-1:0]        cnt, cnt_n;
  logic                 busy, done;

  // One shift step: logical shift by one with zero fill.
  function automatic logic [DATAWIDTH-1:0] shift_step(
    input logic [DATAWIDTH-1:0] r,
    input logic                 right
  );
    return right ? (r >> 1) : (r << 1);
  endfunction

  assign row_shifted = shift_step(row, dir);

  // Next-state and next-register logic.
  always_comb begin
    state_n = state;
    row_n   = row;
    dir_n   = dir;
    tick_n  = tick;
    cnt_n   = cnt;

    // A load is accepted in every state. Pause does not block it. In RUN
    // the load wins over a coincident shift step and discards the old run
    // without a done pulse.
    if (SC_STARTSHIFT_load_In) begin
      row_n   = SC_STARTSHIFT_data_InBUS;
      dir_n   = SC_STARTSHIFT_dir_In;
      tick_n  = '0;
      cnt_n   = '0;
      state_n = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!SC_STARTSHIFT_pause_In) begin
            if (tick == TICK_LAST) begin
              tick_n = '0;
              row_n  = row_shifted;
              cnt_n  = cnt + SW'(1);
              // The end test uses the post-shift values, so the run finishes
              // on the same edge as the last shift.
              if ((cnt_n == SHIFT_MAX) || (row_shifted == '0)) begin
                state_n = DONE;
              end
            end else begin
              tick_n = tick + TW'(1);
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  // State register. Busy and done are registered copies of the next state,
  // so the outputs change on the same edge as the state does.
  always_ff @(posedge SC_STARTSHIFT_CLOCK_50) begin
    if (SC_STARTSHIFT_RESET_InHigh) begin
      state <= IDLE;
      row   <= '0;
      dir   <= 1'b0;
      tick  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      dir   <= dir_n;
      tick  <= tick_n;
      cnt   <= cnt_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  assign SC_STARTSHIFT_data_OutBUS = row;
  assign SC_STARTSHIFT_busy_Out    = busy;
  assign SC_STARTSHIFT_done_Out    = done;

endmodule
